// File: rtl/cpu_pkg.sv
// Shared MIPS core constants and the fetch-buffer entry layout.
package cpu_pkg;

  localparam int unsigned INST_W        = 32;
  localparam int unsigned PC_W          = 32;
  localparam int unsigned PC_INC        = 4;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = PC_W + INST_W;

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Synchronous FIFO with flush; head is read combinationally from storage.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [WIDTH-1:0]         o_head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && (r_count != CNT_W'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the fetch PC, issues credit-limited reads to a
// 1-cycle synchronous imem, and squashes buffered/in-flight work on redirect.
module if_stage
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_inst,
  output logic [31:0]       id_pc,
  output logic [31:0]       fetch_pc
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [PC_W-1:0]          r_fpc;
  logic [PC_W-1:0]          r_inflight_pc;
  logic                     r_inflight;
  logic [CNT_W-1:0]         w_count;
  logic [FETCH_ENTRY_W-1:0] w_head_bits;
  fetch_entry_t             w_head;
  fetch_entry_t             w_push_entry;
  logic                     w_credit;
  logic                     w_issue;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_valid;
  logic [PC_W-1:0]          w_target;

  // Credits count buffered plus in-flight reads; a same-cycle pop is not credited.
  assign w_credit = ({1'b0, w_count} + (CNT_W+1)'(r_inflight)) < (CNT_W+1)'(FIFO_DEPTH);
  assign w_issue  = !RST && !redirect && w_credit;
  assign w_target = redirect_pc & ~32'h3;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fpc         <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect) begin
      r_fpc      <= w_target;
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_inflight_pc <= r_fpc;
      r_fpc         <= r_fpc + PC_W'(PC_INC);
      r_inflight    <= 1'b1;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  assign w_push       = r_inflight && !redirect;
  assign w_pop        = w_valid && id_ready && !redirect;
  assign w_push_entry = '{pc: r_inflight_pc, inst: imem_data};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_data  (w_push_entry),
    .o_count (w_count),
    .o_head  (w_head_bits)
  );

  assign w_head    = fetch_entry_t'(w_head_bits);
  assign w_valid   = (w_count != '0);
  assign id_valid  = w_valid;
  assign id_inst   = w_valid ? w_head.inst : NOP_INST;
  assign id_pc     = w_valid ? w_head.pc : 32'h0;
  assign imem_en   = w_issue;
  assign imem_addr = r_fpc[ADDR_W-1:0];
  assign fetch_pc  = r_fpc;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a 1-cycle synchronous instruction memory.
module tb_if_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] fetch_pc;

  int total = 0;
  int bad   = 0;

  if_stage dut (
    .CLK         (CLK),
    .RST         (RST),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_inst     (id_inst),
    .id_pc       (id_pc),
    .fetch_pc    (fetch_pc)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return 32'hA000_0000 | {24'h0, a};
  endfunction

  always @(posedge CLK) begin
    if (imem_en) imem_data <= mem_word(imem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next falling edge (mid-cycle sample/drive point).
  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    RST      = 1'b1;
    redirect = 1'b0;
    id_ready = ready;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
  endtask

  initial begin
    // Streaming from reset: first instruction two cycles after release.
    do_reset(1'b1);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_inst", id_inst, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_fpc", fetch_pc, 32'h0);
    chk("c0_en", 32'(imem_en), 32'd1);
    chk("c0_addr", 32'(imem_addr), 32'h00);
    tick();
    chk("c1_valid", 32'(id_valid), 32'd0);
    chk("c1_addr", 32'(imem_addr), 32'h04);
    tick();
    chk("c2_valid", 32'(id_valid), 32'd1);
    chk("c2_inst", id_inst, 32'hA000_0000);
    chk("c2_pc", id_pc, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("stream_valid", 32'(id_valid), 32'd1);
      chk("stream_pc", id_pc, 32'(4 * k));
      chk("stream_inst", id_inst, 32'hA000_0000 | 32'(4 * k));
    end

    // Backpressure: exactly four reads, then no issue while the buffer is full.
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("bp_issue_en", 32'(imem_en), 32'd1);
      chk("bp_issue_addr", 32'(imem_addr), 32'(4 * k));
      tick();
    end
    for (int k = 4; k < 10; k++) begin
      chk("bp_stall_en", 32'(imem_en), 32'd0);
      chk("bp_stall_pc", id_pc, 32'h0);
      tick();
    end
    id_ready = 1'b1;
    #1;
    chk("bp_full_en", 32'(imem_en), 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_drain_valid", 32'(id_valid), 32'd1);
      chk("bp_drain_pc", id_pc, 32'(4 * k));
      if (k == 1) begin
        chk("bp_next_en", 32'(imem_en), 32'd1);
        chk("bp_next_addr", 32'(imem_addr), 32'h10);
      end
      tick();
    end

    // Redirect with three entries buffered and one read in flight.
    do_reset(1'b0);
    repeat (4) tick();
    chk("rd_pre_valid", 32'(id_valid), 32'd1);
    chk("rd_pre_pc", id_pc, 32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    #1;
    chk("rd_cycle_en", 32'(imem_en), 32'd0);
    tick();
    redirect = 1'b0;
    id_ready = 1'b1;
    #1;
    chk("rd_r1_valid", 32'(id_valid), 32'd0);
    chk("rd_r1_en", 32'(imem_en), 32'd1);
    chk("rd_r1_addr", 32'(imem_addr), 32'h40);
    tick();
    chk("rd_r2_valid", 32'(id_valid), 32'd0);
    tick();
    chk("rd_r3_valid", 32'(id_valid), 32'd1);
    chk("rd_r3_pc", id_pc, 32'h40);
    chk("rd_r3_inst", id_inst, 32'hA000_0040);
    tick();
    chk("rd_r4_pc", id_pc, 32'h44);
    tick();

    // Address wrap: imem_addr rolls to 0 while the PC continues to 0x100.
    redirect    = 1'b1;
    redirect_pc = 32'hF8;
    tick();
    redirect = 1'b0;
    #1;
    chk("wr_r1_addr", 32'(imem_addr), 32'hF8);
    chk("wr_r1_valid", 32'(id_valid), 32'd0);
    tick();
    chk("wr_r2_fpc", fetch_pc, 32'hFC);
    tick();
    chk("wr_r3_addr", 32'(imem_addr), 32'h00);
    chk("wr_r3_fpc", fetch_pc, 32'h100);
    chk("wr_r3_pc", id_pc, 32'hF8);
    tick();
    chk("wr_r4_pc", id_pc, 32'hFC);
    tick();
    chk("wr_r5_pc", id_pc, 32'h100);
    chk("wr_r5_inst", id_inst, 32'hA000_0000);
    tick();
    chk("wr_r6_pc", id_pc, 32'h104);

    // Unaligned redirect coinciding with a valid pop.
    chk("ua_pre_valid", 32'(id_valid), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h23;
    tick();
    redirect = 1'b0;
    #1;
    chk("ua_r1_fpc", fetch_pc, 32'h20);
    chk("ua_r1_addr", 32'(imem_addr), 32'h20);
    chk("ua_r1_valid", 32'(id_valid), 32'd0);
    tick();
    tick();
    chk("ua_r3_pc", id_pc, 32'h20);
    chk("ua_r3_inst", id_inst, 32'hA000_0020);
    tick();
    chk("ua_r4_pc", id_pc, 32'h24);

    // Asynchronous reset between edges, mid-stream.
    #1;
    RST = 1'b1;
    #1;
    chk("ar_valid", 32'(id_valid), 32'd0);
    chk("ar_en", 32'(imem_en), 32'd0);
    chk("ar_pc", id_pc, 32'h0);
    chk("ar_fpc", fetch_pc, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("ar_c0_addr", 32'(imem_addr), 32'h00);
    chk("ar_c0_en", 32'(imem_en), 32'd1);
    tick();
    chk("ar_c1_valid", 32'(id_valid), 32'd0);
    tick();
    chk("ar_c2_valid", 32'(id_valid), 32'd1);
    chk("ar_c2_pc", id_pc, 32'h0);
    chk("ar_c2_inst", id_inst, 32'hA000_0000);
    tick();
    chk("ar_c3_pc", id_pc, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
